// File: rtl/exu_stage_if.sv
// exu_stage_if: connection bundle for the execute stage.
//   Upstream side : adu_valid_i, adu_exu_bus_i (decoded bus), ready_o (backpressure)
//   Memory side   : mem_req_o/mem_wen_o/mem_addr_o/mem_wmask_o/mem_wdata_o,
//                   mem_gnt_i, mem_rvalid_i, mem_rdata_i
//   Writeback side: exu_wbu_bus_o, valid_o, misalign_o
// master = the execute stage itself, slave = its environment (decode, memory, WBU).
interface exu_stage_if #(
  parameter int IN_W  = 233,
  parameter int OUT_W = 119
);
  logic             adu_valid_i;
  logic [IN_W-1:0]  adu_exu_bus_i;
  logic             ready_o;
  logic             mem_req_o;
  logic             mem_wen_o;
  logic [31:0]      mem_addr_o;
  logic [3:0]       mem_wmask_o;
  logic [31:0]      mem_wdata_o;
  logic             mem_gnt_i;
  logic             mem_rvalid_i;
  logic [31:0]      mem_rdata_i;
  logic [OUT_W-1:0] exu_wbu_bus_o;
  logic             valid_o;
  logic             misalign_o;

  modport master (
    input  adu_valid_i, adu_exu_bus_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output ready_o, mem_req_o, mem_wen_o, mem_addr_o, mem_wmask_o, mem_wdata_o,
           exu_wbu_bus_o, valid_o, misalign_o
  );

  modport slave (
    output adu_valid_i, adu_exu_bus_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  ready_o, mem_req_o, mem_wen_o, mem_addr_o, mem_wmask_o, mem_wdata_o,
           exu_wbu_bus_o, valid_o, misalign_o
  );
endinterface

// File: rtl/exu_stage.sv
// exu_stage: execute stage behind the address/operand decode stage.
// Latches the decoded bus, computes the ALU result (also the memory address and
// jump target), runs one outstanding load/store on a req/gnt/rvalid port and
// presents a one-cycle-valid writeback bus.
// Ports:
//   clock - system clock
//   reset - synchronous, active-low reset
//   bus   - exu_stage_if.master (upstream handshake, memory port, writeback bus)
module exu_stage #(
  parameter int IN_W  = 233,
  parameter int OUT_W = 119
) (
  input  logic     clock,
  input  logic     reset,
  exu_stage_if.master bus
);

  typedef struct packed {
    logic        res_from_compare;
    logic        compare_result;
    logic        excp_flush;
    logic        xret_flush;
    logic        break_signal;
    logic [31:0] snpc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rs2_value;
    logic [5:0]  alu_op;
    logic        res_from_mem;
    logic        res_from_csr;
    logic        gr_we;
    logic        csr_we;
    logic [3:0]  mem_re;
    logic [3:0]  mem_we;
    logic [4:0]  rd;
    logic        jmp_flag;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_value;
  } adu_bus_t;

  typedef enum logic [1:0] {IDLE, EXEC, MREQ, MWAIT} state_t;

  function automatic logic [31:0] alu_calc(input logic [5:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0]        r;
    logic signed [31:0] sa;
    sa = a;
    r  = '0;
    case (op[5:4])
      2'b11: r = op[0] ? (a - b) : (a + b);
      2'b01: begin
        case (op[3:1])
          3'b011:  r = a ^ b;
          3'b111:  r = a | b;
          3'b100:  r = a & b;
          default: r = '0;
        endcase
      end
      2'b10: begin
        if (!op[0])     r = a << b[4:0];
        else if (op[1]) r = sa >>> b[4:0];
        else            r = a >> b[4:0];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Access size is taken from the strobe pattern: bit3 set means word, bit1 half.
  function automatic logic is_misaligned(input logic [3:0] mask, input logic [1:0] off);
    if (mask[3])      return off != 2'b00;
    else if (mask[1]) return off[0];
    else              return 1'b0;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] lane, input logic [3:0] re);
    case (re)
      4'b0101: return {{24{lane[7]}}, lane[7:0]};
      4'b0001: return {24'b0, lane[7:0]};
      4'b0111: return {{16{lane[15]}}, lane[15:0]};
      4'b0011: return {16'b0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  state_t          state, state_nxt;
  logic [IN_W-1:0] bus_p0;
  adu_bus_t        d;
  logic [31:0]     alu_result;
  logic            is_load, is_store, is_mem, misalign;
  logic [3:0]      acc_mask;
  logic [31:0]     lane, load_data, wb_data;
  logic            ready, req, vld, mis;

  // ---- stage p0: decoded bus register ----
  always_ff @(posedge clock) begin
    if (!reset)
      bus_p0 <= '0;
    else if (bus.adu_valid_i && state == IDLE)
      bus_p0 <= bus.adu_exu_bus_i;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- execute: combinational from the p0 register ----
  assign d          = adu_bus_t'(bus_p0);
  assign alu_result = alu_calc(d.alu_op, d.src1, d.src2);

  // A nonzero mem_re wins when both masks are set, so such an op is a load.
  assign is_load  = |d.mem_re;
  assign is_store = !is_load && (|d.mem_we);
  assign is_mem   = is_load || is_store;
  assign acc_mask = is_load ? d.mem_re : d.mem_we;
  assign misalign = is_mem && is_misaligned(acc_mask, alu_result[1:0]);

  assign lane      = bus.mem_rdata_i >> {alu_result[1:0], 3'b000};
  assign load_data = fmt_load(lane, d.mem_re);

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    req       = 1'b0;
    vld       = 1'b0;
    mis       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.adu_valid_i) state_nxt = EXEC;
      end
      EXEC: begin
        if (!is_mem) begin
          vld       = 1'b1;
          state_nxt = IDLE;
        end else if (misalign) begin
          vld       = 1'b1;
          mis       = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = MREQ;
        end
      end
      MREQ: begin
        req = 1'b1;
        if (bus.mem_gnt_i) begin
          if (is_store) begin
            vld       = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = MWAIT;
          end
        end
      end
      MWAIT: begin
        if (bus.mem_rvalid_i) begin
          vld       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_data = alu_result;
    if (mis)                    wb_data = '0;
    else if (d.res_from_compare) wb_data = {31'b0, d.compare_result};
    else if (d.jmp_flag)        wb_data = d.snpc;
    else if (d.res_from_csr)    wb_data = d.csr_value;
    else if (d.res_from_mem)    wb_data = load_data;
  end

  // ---- outputs ----
  assign bus.ready_o     = ready;
  assign bus.valid_o     = vld;
  assign bus.misalign_o  = mis;
  assign bus.mem_req_o   = req;
  assign bus.mem_wen_o   = is_store;
  assign bus.mem_addr_o  = {alu_result[31:2], 2'b00};
  assign bus.mem_wmask_o = is_store ? (d.mem_we << alu_result[1:0]) : 4'b0000;
  assign bus.mem_wdata_o = d.rs2_value << {alu_result[1:0], 3'b000};

  assign bus.exu_wbu_bus_o = OUT_W'({d.excp_flush, d.xret_flush, d.break_signal,
                                     d.gr_we, d.csr_we, d.rd, wb_data, d.csr_addr,
                                     d.csr_wdata, d.jmp_flag, alu_result});

endmodule
